// File: rtl/clk_delay_measure_pkg.sv
// ----------------------------------------------------------------------------
// clk_delay_measure_pkg
//   Shared types and defaults for the clk_delay_measure block.
//   - meas_state_t : two-state measurement FSM encoding
//   - DEFAULT_*    : default parameter values used by the top level
// Ports: none (package).
// ----------------------------------------------------------------------------
package clk_delay_measure_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } meas_state_t;

  localparam int DEFAULT_CNT_W       = 32;
  localparam int DEFAULT_SYNC_STAGES = 2;
  localparam int DEFAULT_TIMEOUT     = 1023;

endpackage : clk_delay_measure_pkg

// File: rtl/sync_rise_detect.sv
// ----------------------------------------------------------------------------
// sync_rise_detect
//   Brings one asynchronous level into the i_clk domain through a
//   SYNC_STAGES-deep flop chain, then flags its rising edge for one cycle.
//   Both measurement inputs use an identical instance, so the synchronizer
//   latency is the same on both paths and cancels out of the measured delay.
// Parameters:
//   SYNC_STAGES  number of synchronizer flops (>= 2)
// Ports:
//   i_clk    in   sampling clock
//   i_rst    in   asynchronous, active-high reset
//   i_async  in   level asynchronous to i_clk
//   o_rise   out  one-cycle pulse on a synchronized 0->1 transition
// ----------------------------------------------------------------------------
module sync_rise_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_sync_d;

  // NOTE: sequential state is always written with non-blocking (<=)
  // assignments so every flop samples the pre-edge value of its neighbour;
  // blocking assignments here would collapse the chain into one flop.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync   <= '0;
      r_sync_d <= 1'b0;
    end else begin
      r_sync   <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_sync_d <= r_sync[SYNC_STAGES-1];
    end
  end

  // Edge detect compares the synchronized level with its one-cycle-old copy.
  assign o_rise = r_sync[SYNC_STAGES-1] & ~r_sync_d;

endmodule : sync_rise_detect

// File: rtl/clk_delay_measure.sv
// ----------------------------------------------------------------------------
// clk_delay_measure
//   Measures, in fast_clk cycles, how far the rising edge of delayed_clk lags
//   the rising edge of slow_clk. Both inputs are synchronized into the
//   fast_clk domain; the lag between the two synchronized rise pulses is
//   counted by a two-state FSM (IDLE / MEASURE).
//
// Optional build macro:
//   CLK_DELAY_MEASURE_MINMAX_EN  adds delay_min / delay_max trackers that
//                                follow every reported measurement.
//
// Parameters:
//   CNT_W        width of the counter and delay_count
//   SYNC_STAGES  flops per input synchronizer (>= 2)
//   TIMEOUT      count at which a missing delayed edge is declared (< 2**CNT_W)
// Ports:
//   fast_clk     in   measurement clock, all state on its rising edge
//   reset        in   asynchronous, active-high
//   slow_clk     in   reference clock (async)
//   delayed_clk  in   delayed copy of slow_clk (async)
//   delay_count  out  last measured delay, held until the next measurement
//   delay_valid  out  1-cycle pulse, delay_count updated
//   timeout      out  1-cycle pulse, no delayed edge within TIMEOUT counts
//   overrun      out  1-cycle pulse, new slow edge before the delayed edge
//   busy         out  high while a measurement is in progress
//   delay_min    out  smallest reported delay   (MINMAX build only)
//   delay_max    out  largest reported delay    (MINMAX build only)
// ----------------------------------------------------------------------------
module clk_delay_measure
  import clk_delay_measure_pkg::*;
#(
  parameter int CNT_W       = DEFAULT_CNT_W,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter int TIMEOUT     = DEFAULT_TIMEOUT
) (
  input  logic             fast_clk,
  input  logic             reset,
  input  logic             slow_clk,
  input  logic             delayed_clk,
  output logic [CNT_W-1:0] delay_count,
  output logic             delay_valid,
  output logic             timeout,
  output logic             overrun,
  output logic             busy
`ifdef CLK_DELAY_MEASURE_MINMAX_EN
  ,
  output logic [CNT_W-1:0] delay_min,
  output logic [CNT_W-1:0] delay_max
`endif
);

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  // --------------------------------------------------------------------------
  // Input synchronizers + rise detection
  // --------------------------------------------------------------------------
  logic w_slow_rise;
  logic w_delayed_rise;

  sync_rise_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_slow (
    .i_clk   (fast_clk),
    .i_rst   (reset),
    .i_async (slow_clk),
    .o_rise  (w_slow_rise)
  );

  sync_rise_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_delayed (
    .i_clk   (fast_clk),
    .i_rst   (reset),
    .i_async (delayed_clk),
    .o_rise  (w_delayed_rise)
  );

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  meas_state_t r_state;
  meas_state_t w_state_next;

  always_ff @(posedge fast_clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] r_cnt;

  // NOTE: every signal assigned in an always_comb gets a default on the first
  // line; any path that leaves one unassigned would otherwise infer a latch.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        // Coincident edges are a zero-delay result and need no measurement.
        if (w_slow_rise && !w_delayed_rise) w_state_next = MEASURE;
      end
      MEASURE: begin
        if (w_delayed_rise)            w_state_next = w_slow_rise ? MEASURE : IDLE;
        else if (w_slow_rise)          w_state_next = MEASURE;
        else if (r_cnt == TIMEOUT_CNT) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output / datapath decode (values registered below)
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] r_delay_count;
  logic [CNT_W-1:0] w_cnt_next;
  logic [CNT_W-1:0] w_delay_count_next;
  logic             w_valid_next;
  logic             w_timeout_next;
  logic             w_overrun_next;

  always_comb begin
    w_cnt_next         = r_cnt;
    w_delay_count_next = r_delay_count;
    w_valid_next       = 1'b0;
    w_timeout_next     = 1'b0;
    w_overrun_next     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_slow_rise && w_delayed_rise) begin
          w_delay_count_next = '0;
          w_valid_next       = 1'b1;
        end else if (w_slow_rise) begin
          // The cycle after the slow edge is count 1, so a delayed edge seen
          // N cycles after the slow edge reports exactly N.
          w_cnt_next = CNT_ONE;
        end
      end
      MEASURE: begin
        if (w_delayed_rise) begin
          w_delay_count_next = r_cnt;
          w_valid_next       = 1'b1;
          // A slow edge in the same cycle opens the next measurement at once.
          if (w_slow_rise) w_cnt_next = CNT_ONE;
        end else if (w_slow_rise) begin
          w_overrun_next = 1'b1;
          w_cnt_next     = CNT_ONE;
        end else if (r_cnt == TIMEOUT_CNT) begin
          w_timeout_next = 1'b1;
        end else begin
          // Bounded by TIMEOUT above, so this never wraps.
          w_cnt_next = r_cnt + CNT_ONE;
        end
      end
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Registered outputs and counter
  // --------------------------------------------------------------------------
  logic r_delay_valid;
  logic r_timeout;
  logic r_overrun;
  logic r_busy;

  always_ff @(posedge fast_clk or posedge reset) begin
    if (reset) begin
      r_cnt         <= '0;
      r_delay_count <= '0;
      r_delay_valid <= 1'b0;
      r_timeout     <= 1'b0;
      r_overrun     <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_cnt         <= w_cnt_next;
      r_delay_count <= w_delay_count_next;
      r_delay_valid <= w_valid_next;
      r_timeout     <= w_timeout_next;
      r_overrun     <= w_overrun_next;
      // Registered from the next state so busy tracks r_state exactly.
      r_busy        <= (w_state_next == MEASURE);
    end
  end

  assign delay_count = r_delay_count;
  assign delay_valid = r_delay_valid;
  assign timeout     = r_timeout;
  assign overrun     = r_overrun;
  assign busy        = r_busy;

`ifdef CLK_DELAY_MEASURE_MINMAX_EN
  // --------------------------------------------------------------------------
  // Min / max trackers: updated on the same edge that loads delay_count, so
  // they already include the value flagged by delay_valid.
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] r_min;
  logic [CNT_W-1:0] r_max;

  always_ff @(posedge fast_clk or posedge reset) begin
    if (reset) begin
      r_min <= '1;
      r_max <= '0;
    end else if (w_valid_next) begin
      if (w_delay_count_next < r_min) r_min <= w_delay_count_next;
      if (w_delay_count_next > r_max) r_max <= w_delay_count_next;
    end
  end

  assign delay_min = r_min;
  assign delay_max = r_max;
`endif

endmodule : clk_delay_measure

// File: tb/tb_clk_delay_measure.sv
// ----------------------------------------------------------------------------
// tb_clk_delay_measure
//   Two instances share the stimulus: dut_a with TIMEOUT=1023, dut_b with
//   TIMEOUT=50. slow_clk / delayed_clk are driven 2 ns after a fast_clk edge
//   with a whole-cycle lag between them, so both synchronizers see the edges
//   with identical phase and the expected delay is exact.
// ----------------------------------------------------------------------------
module tb_clk_delay_measure;

  localparam int CNT_W = 32;

  typedef struct {
    string name;
    bit    on_b;       // 0: check dut_a (TIMEOUT 1023), 1: check dut_b (TIMEOUT 50)
    int    lag;        // delayed_clk lag in fast cycles, -1 = held low
    int    period;     // slow_clk period in fast cycles
    int    ncyc;       // stimulus length in fast cycles
    int    exp_valid;
    int    exp_to;
    int    exp_ovr;
    int    exp_count;
  } vec_t;

  logic fast_clk    = 1'b0;
  logic reset       = 1'b1;
  logic slow_clk    = 1'b0;
  logic delayed_clk = 1'b0;

  logic [CNT_W-1:0] cnt_a, cnt_b;
  logic val_a, to_a, ovr_a, busy_a;
  logic val_b, to_b, ovr_b, busy_b;
`ifdef CLK_DELAY_MEASURE_MINMAX_EN
  logic [CNT_W-1:0] min_a, max_a, min_b, max_b;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Cumulative pulse counters (high cycles, sampled on the falling edge).
  int nv_a = 0, nt_a = 0, no_a = 0;
  int nv_b = 0, nt_b = 0, no_b = 0;
  int s_va, s_ta, s_oa, s_vb, s_tb, s_ob;

  always #5 fast_clk = ~fast_clk;

  clk_delay_measure #(.CNT_W(CNT_W), .SYNC_STAGES(2), .TIMEOUT(1023)) dut_a (
    .fast_clk    (fast_clk),
    .reset       (reset),
    .slow_clk    (slow_clk),
    .delayed_clk (delayed_clk),
    .delay_count (cnt_a),
    .delay_valid (val_a),
    .timeout     (to_a),
    .overrun     (ovr_a),
    .busy        (busy_a)
`ifdef CLK_DELAY_MEASURE_MINMAX_EN
    ,
    .delay_min   (min_a),
    .delay_max   (max_a)
`endif
  );

  clk_delay_measure #(.CNT_W(CNT_W), .SYNC_STAGES(2), .TIMEOUT(50)) dut_b (
    .fast_clk    (fast_clk),
    .reset       (reset),
    .slow_clk    (slow_clk),
    .delayed_clk (delayed_clk),
    .delay_count (cnt_b),
    .delay_valid (val_b),
    .timeout     (to_b),
    .overrun     (ovr_b),
    .busy        (busy_b)
`ifdef CLK_DELAY_MEASURE_MINMAX_EN
    ,
    .delay_min   (min_b),
    .delay_max   (max_b)
`endif
  );

  always @(negedge fast_clk) begin
    if (val_a) nv_a++;
    if (to_a)  nt_a++;
    if (ovr_a) no_a++;
    if (val_b) nv_b++;
    if (to_b)  nt_b++;
    if (ovr_b) no_b++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic snapshot();
    s_va = nv_a; s_ta = nt_a; s_oa = no_a;
    s_vb = nv_b; s_tb = nt_b; s_ob = no_b;
  endtask

  task automatic apply_reset();
    reset       = 1'b1;
    slow_clk    = 1'b0;
    delayed_clk = 1'b0;
    repeat (3) @(posedge fast_clk);
    #2 reset = 1'b0;
    repeat (2) @(posedge fast_clk);
  endtask

  // slow_clk: 50% duty, rising at t = 0, period, 2*period ...
  // delayed_clk: same waveform shifted by lag cycles (low before the shift).
  task automatic drive(input int lag, input int period, input int ncyc);
    for (int t = 0; t < ncyc; t++) begin
      @(posedge fast_clk);
      #2;
      slow_clk    = ((t % period) < (period / 2));
      delayed_clk = (lag >= 0 && t >= lag) ? (((t - lag) % period) < (period / 2)) : 1'b0;
    end
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{"lag10_a",   1'b0,  10, 200, 1000, 5, 0, 0, 10};
    vecs[1] = '{"lag0_a",    1'b0,   0, 200, 1000, 5, 0, 0, 0};
    vecs[2] = '{"lag1_a",    1'b0,   1, 200, 1000, 5, 0, 0, 1};
    vecs[3] = '{"lag300_a",  1'b0, 300, 200, 1000, 4, 0, 1, 100};
    vecs[4] = '{"nodly_a",   1'b0,  -1, 200, 1000, 0, 0, 4, 0};
    vecs[5] = '{"nodly_b",   1'b1,  -1, 200, 1000, 0, 5, 0, 0};
    vecs[6] = '{"lag50_b",   1'b1,  50, 200, 1000, 5, 0, 0, 50};
    vecs[7] = '{"lag51_b",   1'b1,  51, 200, 1000, 0, 5, 0, 0};
    vecs[8] = '{"lag300_b",  1'b1, 300, 200, 1000, 0, 5, 0, 0};

    // ---- reset state ----
    apply_reset();
    @(negedge fast_clk);
    check("rst_count_a", cnt_a, 0);
    check("rst_pulses_a", {val_a, to_a, ovr_a, busy_a}, 0);
    check("rst_count_b", cnt_b, 0);
    check("rst_pulses_b", {val_b, to_b, ovr_b, busy_b}, 0);
`ifdef CLK_DELAY_MEASURE_MINMAX_EN
    check("rst_min_a", min_a, {CNT_W{1'b1}});
    check("rst_max_a", max_a, 0);
`endif

    // ---- table-driven periodic scenarios ----
    for (int i = 0; i < 9; i++) begin
      apply_reset();
      snapshot();
      drive(vecs[i].lag, vecs[i].period, vecs[i].ncyc);
      @(negedge fast_clk);
      if (!vecs[i].on_b) begin
        check({vecs[i].name, "_valid"},   nv_a - s_va, vecs[i].exp_valid);
        check({vecs[i].name, "_timeout"}, nt_a - s_ta, vecs[i].exp_to);
        check({vecs[i].name, "_overrun"}, no_a - s_oa, vecs[i].exp_ovr);
        check({vecs[i].name, "_count"},   cnt_a,       vecs[i].exp_count);
      end else begin
        check({vecs[i].name, "_valid"},   nv_b - s_vb, vecs[i].exp_valid);
        check({vecs[i].name, "_timeout"}, nt_b - s_tb, vecs[i].exp_to);
        check({vecs[i].name, "_overrun"}, no_b - s_ob, vecs[i].exp_ovr);
        check({vecs[i].name, "_count"},   cnt_b,       vecs[i].exp_count);
      end
    end

    // ---- delay_count holds across timeouts ----
    apply_reset();
    drive(10, 200, 400);
    @(negedge fast_clk);
    check("hold_pre_count_b", cnt_b, 10);
    snapshot();
    drive(-1, 200, 400);
    @(negedge fast_clk);
    check("hold_timeouts_b", nt_b - s_tb, 2);
    check("hold_valid_b", nv_b - s_vb, 0);
    check("hold_count_b", cnt_b, 10);

    // ---- reset in the middle of a measurement ----
    apply_reset();
    drive(20, 200, 200);
    @(negedge fast_clk);
    check("mid_pre_count_a", cnt_a, 20);
    drive(20, 200, 8);           // slow edge at t=0, busy from cycle 3
    @(negedge fast_clk);
    check("mid_busy_a", busy_a, 1);
    snapshot();
    #1 reset = 1'b1;
    #1;
    check("mid_rst_count_a", cnt_a, 0);
    check("mid_rst_flags_a", {val_a, to_a, ovr_a, busy_a}, 0);
    slow_clk    = 1'b0;
    delayed_clk = 1'b0;
    repeat (2) @(posedge fast_clk);
    #2 reset = 1'b0;
    repeat (2) @(posedge fast_clk);
    @(negedge fast_clk);
    check("mid_no_pulse_a", (nv_a - s_va) + (nt_a - s_ta) + (no_a - s_oa), 0);
    snapshot();
    drive(20, 200, 400);
    @(negedge fast_clk);
    check("post_rst_valid_a", nv_a - s_va, 2);
    check("post_rst_overrun_a", no_a - s_oa, 0);
    check("post_rst_count_a", cnt_a, 20);

`ifdef CLK_DELAY_MEASURE_MINMAX_EN
    // ---- min / max tracking ----
    apply_reset();
    snapshot();
    drive(8, 200, 200);
    drive(12, 200, 200);
    drive(10, 200, 200);
    @(negedge fast_clk);
    check("mm_valid_a", nv_a - s_va, 3);
    check("mm_count_a", cnt_a, 10);
    check("mm_min_a", min_a, 8);
    check("mm_max_a", max_a, 12);
    // Timeouts on dut_b must leave its trackers untouched.
    check("mm_min_b", min_b, 8);
    check("mm_max_b", max_b, 12);
    drive(-1, 200, 200);
    @(negedge fast_clk);
    check("mm_to_min_b", min_b, 8);
    check("mm_to_max_b", max_b, 12);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d failed so far", n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule : tb_clk_delay_measure
